// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run sequencer.
//   state_t : run controller states
//   CNT_W   : width of the reported counters
//   CNT_MAX : saturation value of the change counter
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/out_change_monitor.sv
// Tracks the CPU output bus while sampling is enabled.
// Ports:
//   CLK        in  : clock, rising edge
//   clear      in  : synchronous clear of LAST_OUT and CHANGE_CNT (wins over sampling)
//   sample_en  in  : sample CPU_OUT on this edge
//   CPU_OUT    in  : CPU output bus
//   LAST_OUT   out : most recent sample
//   CHANGE_CNT out : samples that differed from the previous one, saturating
module out_change_monitor
  import cpu_run_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              clear,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] CPU_OUT,
  output logic [DATA_W-1:0] LAST_OUT,
  output logic [CNT_W-1:0]  CHANGE_CNT
);

  always_ff @(posedge CLK) begin
    if (clear) begin
      LAST_OUT   <= '0;
      CHANGE_CNT <= '0;
    end else if (sample_en) begin
      if ((CPU_OUT != LAST_OUT) && (CHANGE_CNT != CNT_MAX))
        CHANGE_CNT <= CHANGE_CNT + 1'b1;
      LAST_OUT <= CPU_OUT;
    end
  end

endmodule

// File: rtl/cpu_run_sequencer.sv
// Run controller for the pipelined CPU: holds it in reset, steps it a fixed
// number of cycles, and reports its final output and change count.
// Ports:
//   CLK, RST   in  : clock and synchronous active-high reset
//   START      in  : run request, honoured only while idle
//   CPU_RST    out : registered reset to the CPU
//   CPU_CE     out : registered step enable to the CPU
//   CPU_OUT    in  : CPU output bus
//   BUSY       out : run in progress (through the DONE cycle)
//   DONE       out : one-cycle completion pulse, results valid
//   LAST_OUT   out : last sampled CPU_OUT
//   CHANGE_CNT out : number of sample-to-sample changes (saturating)
//   CYCLE_CNT  out : step cycles issued in the current or last run
module cpu_run_sequencer
  import cpu_run_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned RUN_CYCLES   = 467,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              CPU_RST,
  output logic              CPU_CE,
  input  logic [DATA_W-1:0] CPU_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] LAST_OUT,
  output logic [CNT_W-1:0]  CHANGE_CNT,
  output logic [CNT_W-1:0]  CYCLE_CNT
);

  localparam logic [31:0] HOLD_LOAD = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] RUN_LOAD  = 32'(RUN_CYCLES - 1);

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        accept;
  logic        sample_en;

  // Next-state logic; the down-counter times both HOLD and RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LOAD;
          accept    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_RUN;
          cnt_nxt   = RUN_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt == '0) state_nxt = ST_DRAIN;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CPU_RST   <= 1'b0;
      CPU_CE    <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      sample_en <= 1'b0;
      CYCLE_CNT <= '0;
    end else begin
      CPU_RST   <= (state_nxt == ST_HOLD);
      CPU_CE    <= (state_nxt == ST_RUN);
      BUSY      <= (state_nxt != ST_IDLE);
      DONE      <= (state_nxt == ST_DONE);
      // CPU_OUT reflects a step one cycle after the step is enabled.
      sample_en <= CPU_CE;
      if (accept)
        CYCLE_CNT <= '0;
      else if (state == ST_RUN)
        CYCLE_CNT <= CYCLE_CNT + 1'b1;
    end
  end

  out_change_monitor #(
    .DATA_W (DATA_W)
  ) u_mon (
    .CLK        (CLK),
    .clear      (RST | accept),
    .sample_en  (sample_en),
    .CPU_OUT    (CPU_OUT),
    .LAST_OUT   (LAST_OUT),
    .CHANGE_CNT (CHANGE_CNT)
  );

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Bench for cpu_run_sequencer: three instances with different run lengths,
// each driven by a small stepping CPU model and checked every cycle against
// a timeline model derived from the acceptance cycle.
module tb_cpu_run_sequencer;

  localparam int NI  = 3;
  localparam int END = 65560;
  localparam int RR [NI] = '{2, 1, 1};
  localparam int NN [NI] = '{5, 3, 65535};

  logic        clk;
  logic        rst      [NI];
  logic        start    [NI];
  logic        cpu_rst  [NI];
  logic        cpu_ce   [NI];
  logic        busy     [NI];
  logic        done     [NI];
  logic [31:0] cpu_out  [NI];
  logic [31:0] last_out [NI];
  logic [15:0] chg_cnt  [NI];
  logic [15:0] cyc_cnt  [NI];
  logic [31:0] k        [NI];

  int checks = 0;
  int errors = 0;

  cpu_run_sequencer #(.RESET_CYCLES(2), .RUN_CYCLES(5), .DATA_W(32)) dut_a (
    .CLK(clk), .RST(rst[0]), .START(start[0]), .CPU_RST(cpu_rst[0]),
    .CPU_CE(cpu_ce[0]), .CPU_OUT(cpu_out[0]), .BUSY(busy[0]), .DONE(done[0]),
    .LAST_OUT(last_out[0]), .CHANGE_CNT(chg_cnt[0]), .CYCLE_CNT(cyc_cnt[0]));

  cpu_run_sequencer #(.RESET_CYCLES(1), .RUN_CYCLES(3), .DATA_W(32)) dut_b (
    .CLK(clk), .RST(rst[1]), .START(start[1]), .CPU_RST(cpu_rst[1]),
    .CPU_CE(cpu_ce[1]), .CPU_OUT(cpu_out[1]), .BUSY(busy[1]), .DONE(done[1]),
    .LAST_OUT(last_out[1]), .CHANGE_CNT(chg_cnt[1]), .CYCLE_CNT(cyc_cnt[1]));

  cpu_run_sequencer #(.RESET_CYCLES(1), .RUN_CYCLES(65535), .DATA_W(32)) dut_c (
    .CLK(clk), .RST(rst[2]), .START(start[2]), .CPU_RST(cpu_rst[2]),
    .CPU_CE(cpu_ce[2]), .CPU_OUT(cpu_out[2]), .BUSY(busy[2]), .DONE(done[2]),
    .LAST_OUT(last_out[2]), .CHANGE_CNT(chg_cnt[2]), .CYCLE_CNT(cyc_cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stepping CPU: step count k, reset by CPU_RST, advanced by CPU_CE.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst[i] || cpu_rst[i]) k[i] <= 32'd0;
      else if (cpu_ce[i])       k[i] <= k[i] + 32'd1;
    end
  end

  // Output after step k: instance a follows 0,0,7,7,9; b is 3k+1; c toggles.
  always_comb begin
    for (int i = 0; i < NI; i++) cpu_out[i] = 32'd0;
    case (k[0])
      32'd3, 32'd4: cpu_out[0] = 32'd7;
      32'd0, 32'd1, 32'd2: cpu_out[0] = 32'd0;
      default: cpu_out[0] = 32'd9;
    endcase
    cpu_out[1] = k[1] * 32'd3 + 32'd1;
    cpu_out[2] = {31'd0, k[2][0]};
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at t=%0t: got %0h, expected %0h", name, inst, $time, act, exp);
    end
  endtask

  // Model state: acceptance cycle (-1 = none since reset) and sampled results.
  int          m_t    [NI];
  logic [31:0] m_last [NI];
  int          m_chg  [NI];

  initial begin
    int rel, r, n, ecyc;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; start[i] = 1'b1;
      m_t[i] = -1; m_last[i] = 32'd0; m_chg[i] = 0;
    end
    for (int c = 1; c <= END; c++) begin
      @(negedge clk);
      // Compare cycle c against the model.
      for (int i = 0; i < NI; i++) begin
        r = RR[i]; n = NN[i];
        rel = (m_t[i] < 0) ? 1000000 : c - m_t[i];
        if (m_t[i] < 0) ecyc = 0;
        else ecyc = (rel - r - 1 < 0) ? 0 : ((rel - r - 1 > n) ? n : rel - r - 1);
        chk("CPU_RST", i, 32'(cpu_rst[i]), 32'(rel >= 1 && rel <= r));
        chk("CPU_CE", i, 32'(cpu_ce[i]), 32'(rel >= r + 1 && rel <= r + n));
        chk("BUSY", i, 32'(busy[i]), 32'(rel >= 1 && rel <= r + n + 2));
        chk("DONE", i, 32'(done[i]), 32'(rel == r + n + 2));
        chk("CYCLE_CNT", i, 32'(cyc_cnt[i]), 32'(ecyc));
        chk("LAST_OUT", i, last_out[i], m_last[i]);
        chk("CHANGE_CNT", i, 32'(chg_cnt[i]), 32'(m_chg[i]));
      end

      // Hand-computed anchors for the model itself.
      if (c == 11) chk("a_rst_c11", 0, 32'(cpu_rst[0]), 32'd1);
      if (c == 12) chk("a_ce_c12", 0, 32'(cpu_ce[0]), 32'd0);
      if (c == 13) chk("a_ce_c13", 0, 32'(cpu_ce[0]), 32'd1);
      if (c == 18) chk("a_ce_c18", 0, 32'(cpu_ce[0]), 32'd0);
      if (c == 19) begin
        chk("a_done_c19", 0, 32'(done[0]), 32'd1);
        chk("a_last_c19", 0, last_out[0], 32'd9);
        chk("a_chg_c19", 0, 32'(chg_cnt[0]), 32'd2);
        chk("a_cyc_c19", 0, 32'(cyc_cnt[0]), 32'd5);
      end
      if (c == 36) begin
        chk("a_abort_ce", 0, 32'(cpu_ce[0]), 32'd0);
        chk("a_abort_busy", 0, 32'(busy[0]), 32'd0);
        chk("a_abort_cyc", 0, 32'(cyc_cnt[0]), 32'd0);
      end
      if (c == 59) chk("a_done_c59", 0, 32'(done[0]), 32'd1);
      if (c == 3)  chk("b_idle_in_rst", 1, 32'(busy[1]), 32'd0);
      if (c == 10 || c == 17 || c == 24) begin
        chk("b_done", 1, 32'(done[1]), 32'd1);
        chk("b_cyc", 1, 32'(cyc_cnt[1]), 32'd3);
        chk("b_last", 1, last_out[1], 32'd10);
        chk("b_chg", 1, 32'(chg_cnt[1]), 32'd3);
      end
      if (c == 65543) begin
        chk("c_done", 2, 32'(done[2]), 32'd1);
        chk("c_chg_sat", 2, 32'(chg_cnt[2]), 32'h0000FFFF);
        chk("c_cyc", 2, 32'(cyc_cnt[2]), 32'd65535);
        chk("c_last", 2, last_out[2], 32'd1);
      end

      // Drive inputs for cycle c.
      for (int i = 0; i < NI; i++) rst[i] = (c <= 3);
      if (c == 35) rst[0] = 1'b1;
      start[0] = (c <= 3) || (c == 10) || (c == 30) || (c == 50);
      start[1] = 1'b1;
      start[2] = (c <= 3) || (c == 5);

      // Advance the model through cycle c.
      for (int i = 0; i < NI; i++) begin
        r = RR[i]; n = NN[i];
        rel = (m_t[i] < 0) ? 1000000 : c - m_t[i];
        if (rst[i]) begin
          m_t[i] = -1; m_last[i] = 32'd0; m_chg[i] = 0;
        end else begin
          if (rel >= r + 2 && rel <= r + n + 1) begin
            if (cpu_out[i] != m_last[i] && m_chg[i] < 65535) m_chg[i]++;
            m_last[i] = cpu_out[i];
          end
          if ((m_t[i] < 0 || rel >= r + n + 3) && start[i]) begin
            m_t[i] = c; m_last[i] = 32'd0; m_chg[i] = 0;
          end
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
